// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo up/down counter with wrap/saturate,
// synchronous clear/load, optional edge-qualified stepping, prescaler and
// terminal-count pulses.
module mod_counter #(
  parameter int WIDTH    = 10,
  parameter int MAX      = 1023,
  parameter int SATURATE = 0,
  parameter int EDGE     = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zc,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] LMAX  = WIDTH'(MAX);
  localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    r_pre;
  logic             r_inc_prev;
  logic             r_dec_prev;
  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             r_zc;

  logic             w_tick;
  logic             w_up;
  logic             w_dn;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_tc_nxt;
  logic             w_zc_nxt;

  assign w_tick = (r_pre == PLAST);
  assign w_up   = (EDGE != 0) ? (inc & ~r_inc_prev) : (inc & w_tick);
  assign w_dn   = (EDGE != 0) ? (dec & ~r_dec_prev) : (dec & w_tick);

  // Free-running prescaler 0..PRESCALE-1; only clear restarts its phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_pre <= '0;
    else if (clear)  r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // Edge-detect history, sampled every cycle regardless of clear/load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inc_prev <= 1'b0;
      r_dec_prev <= 1'b0;
    end else begin
      r_inc_prev <= inc;
      r_dec_prev <= dec;
    end
  end

  // Next count and terminal pulses: clear > load > step; opposing steps cancel
  always_comb begin
    w_out_nxt      = r_out;
    w_tc_nxt       = 1'b0;
    w_zc_nxt       = 1'b0;
    w_load_clamped = (load_value > LMAX) ? LMAX : load_value;
    if (clear) begin
      w_out_nxt = '0;
    end else if (load) begin
      w_out_nxt = w_load_clamped;
    end else if (w_up && !w_dn) begin
      if (r_out == LMAX) begin
        w_tc_nxt = 1'b1;
        if (SATURATE == 0) w_out_nxt = '0;
      end else begin
        w_out_nxt = r_out + 1'b1;
      end
    end else if (w_dn && !w_up) begin
      if (r_out == '0) begin
        w_zc_nxt = 1'b1;
        if (SATURATE == 0) w_out_nxt = LMAX;
      end else begin
        w_out_nxt = r_out - 1'b1;
      end
    end
  end

  // Count and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_tc  <= 1'b0;
      r_zc  <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_tc  <= w_tc_nxt;
      r_zc  <= w_zc_nxt;
    end
  end

  assign out    = r_out;
  assign tc     = r_tc;
  assign zc     = r_zc;
  assign at_max = (r_out == LMAX);
  assign at_min = (r_out == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: a directed vector table for the
// wrapping level-mode counter plus hand-written multi-cycle sequences.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       inc;
  logic       dec;

  logic [3:0] wrap_out, sat_out, pre_out, edge_out;
  logic       wrap_tc, sat_tc, pre_tc, edge_tc;
  logic       wrap_zc, sat_zc, pre_zc, edge_zc;
  logic       wrap_max, sat_max, pre_max, edge_max;
  logic       wrap_min, sat_min, pre_min, edge_min;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .EDGE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .inc(inc), .dec(dec), .out(wrap_out), .tc(wrap_tc), .zc(wrap_zc),
    .at_max(wrap_max), .at_min(wrap_min));

  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1), .EDGE(0), .PRESCALE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .inc(inc), .dec(dec), .out(sat_out), .tc(sat_tc), .zc(sat_zc),
    .at_max(sat_max), .at_min(sat_min));

  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .EDGE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .inc(inc), .dec(dec), .out(pre_out), .tc(pre_tc), .zc(pre_zc),
    .at_max(pre_max), .at_min(pre_min));

  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .EDGE(1), .PRESCALE(1)) u_edge (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .inc(inc), .dec(dec), .out(edge_out), .tc(edge_tc), .zc(edge_zc),
    .at_max(edge_max), .at_min(edge_min));

  typedef struct {
    int clr, ld, lv, up, dn;
    int eout, etc, ezc, emax, emin;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int clr, input int ld, input int lv, input int up,
                         input int dn, input int eout, input int etc, input int ezc,
                         input int emax, input int emin);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.up = up; v.dn = dn;
    v.eout = eout; v.etc = etc; v.ezc = ezc; v.emax = emax; v.emin = emin;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clear = 1'b0; load = 1'b0; load_value = 4'd0; inc = 1'b0; dec = 1'b0;
  endtask

  // One clock: outputs sampled 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  int zc_count;
  int exp_v;

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;

    // Wrap table: 12 held inc steps from 0, then simultaneous-event corners
    for (int k = 1; k <= 12; k++)
      add_vec(0, 0, 0, 1, 0, k % 10, (k == 10) ? 1 : 0, 0,
              (k == 9) ? 1 : 0, (k == 10) ? 1 : 0);
    add_vec(0, 0, 0,  1, 1, 2, 0, 0, 0, 0);  // inc & dec cancel
    add_vec(0, 1, 5,  1, 0, 5, 0, 0, 0, 0);  // load beats inc
    add_vec(1, 1, 7,  0, 0, 0, 0, 0, 0, 1);  // clear beats load
    add_vec(0, 0, 0,  0, 1, 9, 0, 1, 1, 0);  // down-wrap from 0
    add_vec(0, 1, 15, 0, 0, 9, 0, 0, 1, 0);  // load clamps to MAX
    add_vec(0, 0, 0,  1, 0, 0, 1, 0, 0, 1);  // up-wrap from MAX
    add_vec(0, 0, 0,  0, 1, 9, 0, 1, 1, 0);
    add_vec(0, 0, 0,  0, 0, 9, 0, 0, 1, 0);  // pulses last one cycle
    add_vec(1, 0, 0,  1, 0, 0, 0, 0, 0, 1);  // clear discards step, no tc

    do_reset();
    chk("reset_out", wrap_out, 0);
    chk("reset_tc", wrap_tc, 0);
    chk("reset_zc", wrap_zc, 0);
    chk("reset_at_min", wrap_min, 1);
    chk("reset_at_max", wrap_max, 0);
    chk("reset_pre_out", pre_out, 0);

    foreach (vecs[i]) begin
      clear = vecs[i].clr[0]; load = vecs[i].ld[0]; load_value = 4'(vecs[i].lv);
      inc = vecs[i].up[0]; dec = vecs[i].dn[0];
      cyc();
      chk($sformatf("wrap_out[%0d]", i), wrap_out, vecs[i].eout);
      chk($sformatf("wrap_tc[%0d]", i), wrap_tc, vecs[i].etc);
      chk($sformatf("wrap_zc[%0d]", i), wrap_zc, vecs[i].ezc);
      chk($sformatf("wrap_at_max[%0d]", i), wrap_max, vecs[i].emax);
      chk($sformatf("wrap_at_min[%0d]", i), wrap_min, vecs[i].emin);
    end

    // Saturate down: load 12 -> 9, then 11 one-cycle dec pulses
    do_reset();
    load = 1'b1; load_value = 4'd12;
    cyc();
    load = 1'b0;
    chk("sat_load_clamp", sat_out, 9);
    zc_count = 0;
    for (int k = 1; k <= 11; k++) begin
      dec = 1'b1;
      cyc();
      dec = 1'b0;
      exp_v = (9 - k > 0) ? 9 - k : 0;
      chk($sformatf("sat_out[%0d]", k), sat_out, exp_v);
      chk($sformatf("sat_zc[%0d]", k), sat_zc, (k >= 10) ? 1 : 0);
      zc_count += int'(sat_zc);
      cyc();
      chk($sformatf("sat_zc_idle[%0d]", k), sat_zc, 0);
    end
    chk("sat_zc_total", zc_count, 2);
    chk("sat_at_min", sat_min, 1);

    // Prescaler: inc held from reset steps at cycles 4, 8, 12
    do_reset();
    inc = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk($sformatf("pre_out[c%0d]", c), pre_out, c / 4);
    end

    // Prescaler with clear at cycle 6: next step 4 clocks later
    do_reset();
    inc = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      clear = (c == 6);
      cyc();
      exp_v = (c < 6) ? c / 4 : ((c < 10) ? 0 : 1);
      chk($sformatf("pre_clr_out[c%0d]", c), pre_out, exp_v);
    end
    clear = 1'b0;

    // Edge mode: long inc level is a single step
    do_reset();
    inc = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk($sformatf("edge_hold[c%0d]", c), edge_out, 1);
    end
    inc = 1'b0;
    cyc();
    cyc();
    chk("edge_hold_after", edge_out, 1);

    // Edge mode: three 1-clock pulses separated by one low cycle
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      inc = 1'b1;
      cyc();
      chk($sformatf("edge_pulse[%0d]", p), edge_out, p);
      inc = 1'b0;
      cyc();
      chk($sformatf("edge_gap[%0d]", p), edge_out, p);
    end
    dec = 1'b1;
    cyc();
    chk("edge_dec_out", edge_out, 2);
    chk("edge_dec_zc", edge_zc, 0);
    dec = 1'b0;
    cyc();

    // Edge mode: dec edge at 0 wraps to MAX with zc
    do_reset();
    dec = 1'b1;
    cyc();
    chk("edge_dwrap_out", edge_out, 9);
    chk("edge_dwrap_zc", edge_zc, 1);
    dec = 1'b0;
    cyc();
    chk("edge_dwrap_zc_off", edge_zc, 0);

    // Asynchronous reset mid-count, release with inc held high
    do_reset();
    load = 1'b1; load_value = 4'd6;
    cyc();
    load = 1'b0; inc = 1'b1;
    cyc();
    chk("arst_pre_out", edge_out, 7);
    #4;
    reset = 1'b1;
    #1;
    chk("arst_out_immediate", edge_out, 0);
    chk("arst_tc_immediate", edge_tc, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    chk("arst_release_step", edge_out, 1);
    cyc();
    chk("arst_release_hold", edge_out, 1);

    // Asynchronous reset kills a live tc pulse
    inc = 1'b0; load = 1'b1; load_value = 4'd9;
    cyc();
    load = 1'b0; inc = 1'b1;
    cyc();
    chk("arst_tc_set_out", edge_out, 0);
    chk("arst_tc_set", edge_tc, 1);
    #4;
    reset = 1'b1;
    #1;
    chk("arst_tc_cleared", edge_tc, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter, the successor of the basic incrementing counter. It is used for scores, paddle and ball positions, and timing dividers. On top of the basic behaviour it adds a configurable modulus, up and down stepping, wrap or saturate mode, synchronous clear and load, optional rising-edge qualification of the step inputs, a built-in prescaler, and terminal-count pulses. It sits between the game logic (collision/button events) and the display/score logic.

## Interface
- WIDTH, 10: counter width in bits.
- MAX, 1023: terminal value, with 1 ≤ MAX ≤ 2^WIDTH−1. The count range is 0..MAX.
- SATURATE, 0: 0 means wrap at the bounds; 1 means hold at the bounds.
- EDGE, 0: 0 means inc/dec are levels gated by the prescaler; 1 means each rising edge of inc/dec is one step and the prescaler is bypassed.
- PRESCALE, 1: in level mode, one step opportunity every PRESCALE clocks (PRESCALE ≥ 1).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of the count and prescaler.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  value to load; values above MAX are clamped to MAX.
- inc  in  1  step-up request.
- dec  in  1  step-down request.
- out  out  WIDTH  current count, registered.
- tc  out  1  one-cycle pulse on an up-step taken from MAX (wrap or saturate attempt).
- zc  out  1  one-cycle pulse on a down-step taken from 0.
- at_max  out  1  combinational flag, out == MAX.
- at_min  out  1  combinational flag, out == 0.

## Operation
- **Reset** (asynchronous, any time):
  - out = 0, tc = 0, zc = 0.
  - Prescaler count = 0.
  - Edge-detect history registers = 0, so an input held high at reset release counts as one edge in EDGE=1.
- **Priority per cycle:** reset > clear > load > step.
- **clear:** out ← 0, prescaler ← 0, tc/zc ← 0. Edge history still updates.
- **load:** out ← min(load_value, MAX), tc/zc ← 0. The prescaler keeps running.
- **Step request generation:**
  - EDGE=0: up_req = inc & tick, dn_req = dec & tick.
    - tick = 1 when the prescaler count == PRESCALE−1.
    - The prescaler counts 0..PRESCALE−1 continuously, independent of inc/dec.
    - With PRESCALE=1, tick is always 1.
  - EDGE=1: up_req = inc & ~inc_prev, dn_req = dec & ~dec_prev.
    - History registers sample every cycle, including during clear and load.
- **up_req & dn_req together:** no change to out, tc = zc = 0.
- **Up-step:**
  - out < MAX: out + 1.
  - out == MAX: out ← 0 if SATURATE=0, else out holds; tc = 1 in both modes.
- **Down-step:**
  - out > 0: out − 1.
  - out == 0: out ← MAX if SATURATE=0, else out holds; zc = 1 in both modes.
- **Pulse width:** tc and zc are registered and high for exactly the one cycle following the stepping edge. In every other cycle they are 0.
- **Arithmetic:** all at WIDTH bits. When MAX = 2^WIDTH−1 the wrap equals natural overflow; no carry is exposed.

## Timing
- **Step latency:** a request sampled at edge N is reflected in out, tc and zc after edge N. Latency is 1 clock for both level and edge requests.
- **Edge-mode latency:** an input rising between edges N−1 and N produces a step at edge N.
- **Edge-mode throughput:** maximum one step per two clocks, since the input must toggle.
- **Level-mode throughput:** with inc held high, one step every PRESCALE clocks. The first step occurs at the first tick after inc rises, and the prescaler phase is not reset by inc.
- **Clear/load:** effective at the next edge. A step requested in the same cycle is discarded, and no tc/zc is generated.
- **Reset:** asynchronous assertion forces outputs immediately. Deassertion must be synchronous to clk; the block does not synchronise it.
- **Flags:** at_max and at_min follow out combinationally, with no extra latency.

## Test plan
- **Wrap, level mode.** WIDTH=4, MAX=9, SATURATE=0, PRESCALE=1. Hold inc for 12 clocks from reset → out 1..9, 0, 1, 2; tc high only in the cycle out becomes 0; at_max high while out = 9.
- **Saturate down.** SATURATE=1, MAX=9. Load 12 → out = 9. Then pulse dec 11 times → out reaches 0 and holds; zc pulses once per extra dec at 0, twice in total.
- **Prescaler.** PRESCALE=4, inc held from reset → out increments at cycles 4, 8, 12 (out = 1, 2, 3). Assert clear at cycle 6 → out = 0, and the next increment falls 4 clocks after the clear.
- **Edge mode.** EDGE=1, inc held high for 10 clocks then low → exactly one increment. Three 1-clock inc pulses separated by 1 low cycle → out = 3.
- **Simultaneous events.**
  - inc & dec together → out unchanged, tc = zc = 0.
  - load = 1 with load_value = 5 and inc = 1 → out = 5.
  - clear and load together → out = 0.
- **Asynchronous reset mid-count.** out = 7, assert reset between clock edges → out = 0 and tc = 0 before the next edge. After release with inc high (EDGE=1) → one step, out = 1.
